// File: rtl/alu_flags_pkg.sv
// Shared definitions for the ALU flag unit: condition code encodings,
// NZCV bit positions inside the status word, and the query FSM states.
package alu_flags_pkg;

    // Condition codes understood by alu_cond_eval
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Bit positions of each flag in the {N,C,Z,V} status word
    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    // Query FSM: IDLE = no result held, HOLD = result waiting for take_ack
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Pure combinational condition-code evaluator: maps a {N,C,Z,V} word and a
// 4-bit condition code to a single taken/not-taken bit. C=1 means no borrow.
import alu_flags_pkg::*;

module alu_cond_eval (
    input  logic [3:0] flags,
    input  logic [3:0] code,
    output logic       take
);

    logic n, c, z, v;

    assign n = flags[FLAG_N];
    assign c = flags[FLAG_C];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    // Decode the condition against the supplied flags
    always_comb begin
        take = 1'b0;
        case (code)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_MI: take = n;
            COND_PL: take = !n;
            COND_VS: take = v;
            COND_VC: take = !v;
            COND_HI: take = c && !z;
            COND_LS: take = !c || z;
            COND_GE: take = (n == v);
            COND_LT: take = (n != v);
            COND_GT: take = !z && (n == v);
            COND_LE: take = z || (n != v);
            COND_AL: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// ALU flag consumer: captures NZCV into a status register and answers
// condition queries over a valid/ready handshake, one result held until acked.
// Optional NZCV save/restore LIFO is built when FLAG_STACK_EN is defined.
//
// Handshake: a query is accepted on an edge where cond_valid && cond_ready.
// cond_ready = !take_valid || take_ack, so an ack and a new query can share a
// cycle and results stream at one per cycle. take/take_valid hold until acked.
import alu_flags_pkg::*;

module alu_flag_unit #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_we,
    input  logic       n_in,
    input  logic       c_in,
    input  logic       z_in,
    input  logic       v_in,
    output logic [3:0] flags,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       take_valid,
    output logic       take,
    input  logic       take_ack,
    input  logic       push,
    input  logic       pop,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err,
    output logic       dbg_state
);

    logic [3:0] flags_q, flags_d;
    logic [3:0] fwd_flags;
    fsm_state_t state_q, state_d;
    logic       take_q, take_d;
    logic       eval_take;
    logic       accept;

    // Queries issued alongside a flag write see the incoming flags
    assign fwd_flags = flag_we ? {n_in, c_in, z_in, v_in} : flags_q;

    alu_cond_eval u_cond_eval (
        .flags (fwd_flags),
        .code  (cond_code),
        .take  (eval_take)
    );

    assign take_valid = (state_q == ST_HOLD);
    assign take       = take_q;
    assign cond_ready = !take_valid || take_ack;
    assign accept     = cond_valid && cond_ready;
    assign flags      = flags_q;
    assign dbg_state  = state_q;

`ifdef FLAG_STACK_EN
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam logic [PTR_W:0] SP_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] SP_DEPTH = (PTR_W+1)'(STACK_DEPTH);

    logic [3:0]     stack_mem [STACK_DEPTH];
    logic [PTR_W:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic           push_ok, pop_ok;
    logic [PTR_W:0] top_ptr;

    assign stack_full  = (sp_q == SP_DEPTH);
    assign stack_empty = (sp_q == '0);
    assign stack_err   = err_q;
    assign push_ok     = push && !pop && !stack_full;
    assign pop_ok      = pop && !push && !stack_empty;
    assign top_ptr     = sp_q - SP_ONE;

    // Stack pointer, sticky error and status-register next state (pop wins over flag_we)
    always_comb begin
        sp_d    = sp_q;
        err_d   = err_q;
        flags_d = fwd_flags;
        if (push_ok) begin
            sp_d = sp_q + SP_ONE;
        end else if (pop_ok) begin
            sp_d    = top_ptr;
            flags_d = stack_mem[top_ptr[PTR_W-1:0]];
        end
        if ((push && pop) || (push && stack_full) || (pop && stack_empty)) begin
            err_d = 1'b1;
        end
    end

    // Stack storage holds no reset state; only entries below sp_q are ever read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[sp_q[PTR_W-1:0]] <= fwd_flags;
        end
    end

    // Stack pointer and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end
`else
    logic unused_stack_in;

    assign unused_stack_in = push ^ pop;
    assign stack_full      = 1'b0;
    assign stack_empty     = 1'b1;
    assign stack_err       = 1'b0;

    // Status-register next state without the save/restore stack
    always_comb begin
        flags_d = fwd_flags;
    end
`endif

    // Status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Query FSM next state: a new accept overrides the ack-to-idle path
    always_comb begin
        state_d = state_q;
        take_d  = take_q;
        if (accept) begin
            state_d = ST_HOLD;
            take_d  = eval_take;
        end else if (state_q == ST_HOLD && take_ack) begin
            state_d = ST_IDLE;
            take_d  = 1'b0;
        end
    end

    // Query FSM with registered result; reset drops any held result at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            take_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            take_q  <= take_d;
        end
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Testbench for alu_flag_unit: table of flag/condition vectors plus hand
// sequences for forwarding, streaming, stalls, async reset and the stack.
import alu_flags_pkg::*;

module tb_alu_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_we, n_in, c_in, z_in, v_in;
    logic [3:0] flags;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic       cond_ready, take_valid, take, take_ack;
    logic       push, pop;
    logic       stack_full, stack_empty, stack_err;
    logic       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];

    typedef struct {
        logic [3:0] f;
        logic [3:0] code;
        logic       exp;
    } vec_t;

    vec_t vecs[26];

    alu_flag_unit #(.STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
        .n_in(n_in), .c_in(c_in), .z_in(z_in), .v_in(v_in),
        .flags(flags), .cond_valid(cond_valid), .cond_code(cond_code),
        .cond_ready(cond_ready), .take_valid(take_valid), .take(take),
        .take_ack(take_ack), .push(push), .pop(pop),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .stack_err(stack_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // driver: write flags through flag_we and confirm capture
    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1;
        {n_in, c_in, z_in, v_in} = f;
        @(negedge clk);
        flag_we = 1'b0;
        check("flags_capture", flags, f);
    endtask

    // scoreboard pop: DUT must show a valid result matching the oldest expectation
    task automatic check_take(input string nm);
        logic [0:0] e;
        check({nm, "_valid"}, {3'b0, take_valid}, 4'h1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: got no expectation required one", nm);
        end else begin
            e = exp_q.pop_front();
            check(nm, {3'b0, take}, {3'b0, e});
        end
    endtask

    // driver: single query from IDLE, then ack and confirm return to IDLE
    task automatic query_single(input logic [3:0] code, input logic exp);
        cond_valid = 1'b1;
        cond_code  = code;
        exp_q.push_back(exp);
        @(negedge clk);
        cond_valid = 1'b0;
        check_take("take_vec");
        take_ack = 1'b1;
        @(negedge clk);
        take_ack = 1'b0;
        check("idle_after_ack", {3'b0, take_valid}, 4'h0);
    endtask

    initial begin
        vecs[0]  = '{4'b1000, COND_LT, 1'b1};
        vecs[1]  = '{4'b1000, COND_CC, 1'b1};
        vecs[2]  = '{4'b1000, COND_GE, 1'b0};
        vecs[3]  = '{4'b1000, COND_EQ, 1'b0};
        vecs[4]  = '{4'b0100, COND_HI, 1'b1};
        vecs[5]  = '{4'b0100, COND_LS, 1'b0};
        vecs[6]  = '{4'b0100, COND_CS, 1'b1};
        vecs[7]  = '{4'b0110, COND_EQ, 1'b1};
        vecs[8]  = '{4'b0110, COND_HI, 1'b0};
        vecs[9]  = '{4'b0110, COND_LS, 1'b1};
        vecs[10] = '{4'b0110, COND_GT, 1'b0};
        vecs[11] = '{4'b0110, COND_LE, 1'b1};
        vecs[12] = '{4'b1001, COND_GE, 1'b1};
        vecs[13] = '{4'b1001, COND_LT, 1'b0};
        vecs[14] = '{4'b1001, COND_GT, 1'b1};
        vecs[15] = '{4'b1001, COND_VS, 1'b1};
        vecs[16] = '{4'b1001, COND_MI, 1'b1};
        vecs[17] = '{4'b0000, COND_AL, 1'b1};
        vecs[18] = '{4'b0000, COND_NV, 1'b0};
        vecs[19] = '{4'b0000, COND_NE, 1'b1};
        vecs[20] = '{4'b0000, COND_PL, 1'b1};
        vecs[21] = '{4'b0000, COND_VC, 1'b1};
        vecs[22] = '{4'b0001, COND_GT, 1'b0};
        vecs[23] = '{4'b0001, COND_LE, 1'b1};
        vecs[24] = '{4'b1111, COND_NV, 1'b0};
        vecs[25] = '{4'b1111, COND_NE, 1'b0};

        rst_n = 1'b0;
        flag_we = 1'b0; {n_in, c_in, z_in, v_in} = 4'b0000;
        cond_valid = 1'b0; cond_code = 4'h0; take_ack = 1'b0;
        push = 1'b0; pop = 1'b0;
        #2;
        check("rst_flags", flags, 4'h0);
        check("rst_take_valid", {3'b0, take_valid}, 4'h0);
        check("rst_take", {3'b0, take}, 4'h0);
        check("rst_state", {3'b0, dbg_state}, 4'h0);
        check("rst_cond_ready", {3'b0, cond_ready}, 4'h1);
        check("rst_stack", {1'b0, stack_full, stack_empty, stack_err}, 4'b0010);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ack with nothing held is ignored
        take_ack = 1'b1;
        @(negedge clk);
        take_ack = 1'b0;
        check("idle_ack_ignored", {3'b0, take_valid}, 4'h0);

        // table-driven vectors
        for (int i = 0; i < 26; i++) begin
            set_flags(vecs[i].f);
            query_single(vecs[i].code, vecs[i].exp);
        end

        // forwarding: stored Z=0 but incoming Z=1 in the query cycle
        set_flags(4'b0100);
        flag_we = 1'b1;
        {n_in, c_in, z_in, v_in} = 4'b0110;
        cond_valid = 1'b1;
        cond_code  = COND_EQ;
        exp_q.push_back(1'b1);
        @(negedge clk);
        flag_we = 1'b0;
        cond_valid = 1'b0;
        check_take("take_fwd");
        check("flags_fwd", flags, 4'b0110);
        take_ack = 1'b1;
        @(negedge clk);
        take_ack = 1'b0;

        // back-to-back with ack held: EQ then NE against Z=1
        take_ack = 1'b1;
        cond_valid = 1'b1;
        cond_code = COND_EQ;
        exp_q.push_back(1'b1);
        @(negedge clk);
        check("b2b_ready", {3'b0, cond_ready}, 4'h1);
        cond_code = COND_NE;
        exp_q.push_back(1'b0);
        check_take("take_b2b0");
        @(negedge clk);
        cond_valid = 1'b0;
        check_take("take_b2b1");
        @(negedge clk);
        take_ack = 1'b0;
        check("b2b_drain", {3'b0, take_valid}, 4'h0);

        // stall: result stays put for 3 cycles while flags change and a query waits
        cond_valid = 1'b1;
        cond_code = COND_EQ;
        exp_q.push_back(1'b1);
        @(negedge clk);
        cond_code = COND_NE;
        flag_we = 1'b1;
        {n_in, c_in, z_in, v_in} = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            check("stall_ready", {3'b0, cond_ready}, 4'h0);
            check("stall_valid", {3'b0, take_valid}, 4'h1);
            check("stall_take", {3'b0, take}, 4'h1);
            @(negedge clk);
        end
        flag_we = 1'b0;
        cond_valid = 1'b0;
        check_take("take_stall");
        check("stall_flags", flags, 4'b0000);
        take_ack = 1'b1;
        @(negedge clk);
        take_ack = 1'b0;
        check("stall_release", {3'b0, take_valid}, 4'h0);

        // async reset while a result is held
        set_flags(4'b1000);
        cond_valid = 1'b1;
        cond_code = COND_MI;
        @(negedge clk);
        cond_valid = 1'b0;
        check("pre_rst_valid", {3'b0, take_valid}, 4'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {3'b0, take_valid}, 4'h0);
        check("async_rst_flags", flags, 4'h0);
        check("async_rst_take", {3'b0, take}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef FLAG_STACK_EN
        set_flags(4'b1000);
        push = 1'b1;
        @(negedge clk);
        push = 1'b0;
        check("stk_not_empty", {3'b0, stack_empty}, 4'h0);
        set_flags(4'b0110);
        pop = 1'b1;
        flag_we = 1'b1;
        {n_in, c_in, z_in, v_in} = 4'b0011;
        @(negedge clk);
        pop = 1'b0;
        flag_we = 1'b0;
        check("stk_restore", flags, 4'b1000);
        check("stk_empty_again", {3'b0, stack_empty}, 4'h1);
        check("stk_err_clean", {3'b0, stack_err}, 4'h0);
        push = 1'b1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("stk_full", {3'b0, stack_full}, 4'h1);
        check("stk_err_before", {3'b0, stack_err}, 4'h0);
        @(negedge clk);
        push = 1'b0;
        check("stk_err_overflow", {3'b0, stack_err}, 4'h1);
        check("stk_still_full", {3'b0, stack_full}, 4'h1);
`else
        set_flags(4'b1000);
        push = 1'b1;
        @(negedge clk);
        push = 1'b0;
        pop = 1'b1;
        flag_we = 1'b1;
        {n_in, c_in, z_in, v_in} = 4'b0011;
        @(negedge clk);
        pop = 1'b0;
        flag_we = 1'b0;
        check("nostk_flags", flags, 4'b0011);
        check("nostk_status", {1'b0, stack_full, stack_empty, stack_err}, 4'b0010);
`endif

        check("scoreboard_drained", 4'(exp_q.size()), 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
